dma_device_port: RTL and testbench
==================================

# dma_device_port

Device-side endpoint of the DMA request/handshake protocol: turns a local command plus a local word stream into the `rqst`/`rd_wr`/`num_words`/`start_addr` request, and runs the `dev_ack`/`dma_ack` word handshake against the DMA controller. It sits between a peripheral core and the DMA controller, buffering words in a small FIFO in both directions. It reports completion, word count and error status per command.

## Interface
Parameters:
- ADD_LEN, 16: physical address width in words; `start_addr` carries ADD_LEN+1 bits (byte address).
- DATA_LEN, 16: word width.
- BUF_DEPTH, 3: FIFO holds 2^BUF_DEPTH words.
- TIMEOUT_CYCLES, 1024: watchdog limit. Used only with DMA_DEV_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_rd_wr  in  1  1 = memory→device (read), 0 = device→memory (write)
- cmd_words  in  ADD_LEN  word count
- cmd_addr  in  ADD_LEN+1  byte start address
- wr_data / wr_valid / wr_ready  in / in / out  DATA_LEN / 1 / 1  local words to be written to memory
- rd_data / rd_valid / rd_ready  out / out / in  DATA_LEN / 1 / 1  words read from memory
- done  out  1  one-cycle completion pulse
- done_err  out  1  status valid with done: misaligned, short transfer or timeout
- done_count  out  ADD_LEN  words transferred, valid with done
- rqst, rd_wr  out  1, 1  request to the DMA controller
- num_words, start_addr  out  ADD_LEN, ADD_LEN+1  registered command fields
- dev_ack  out  1  device ready: buffer space (read) or data (write)
- dev_in  out  DATA_LEN  FIFO head during write
- dma_ack, dev_out, end_flag  in  1, DATA_LEN, 1  from the DMA controller

## Operation
- Word transfer: occurs on any rising edge where `dma_ack && dev_ack`. In read, `dev_out` is pushed into the FIFO. In write, the FIFO head is popped.
- `dev_ack`:
  - XFER, read: `!fifo_full`.
  - XFER, write: `!fifo_empty`.
  - 0 otherwise.
- FSM states IDLE, XFER, DONE.
- **IDLE**
  - `cmd_ready = 1` iff the FIFO is empty.
  - On accept, latch `rd_wr`, `num_words`, `start_addr` and clear `xfer_cnt`.
  - If `cmd_addr[0] = 1`: go to DONE with the error set; `rqst` is never raised.
  - Otherwise: `rqst <= 1`, go to XFER.
- **XFER**
  - `rqst` is held at 1. All request fields are held stable.
  - Increment `xfer_cnt` on every transfer.
  - Write direction: `wr_ready = !fifo_full`, and the FIFO accepts `wr_data` in XFER only.
- **End of transfer**
  - On the edge where `end_flag = 1`: `rqst <= 0` (registered), go to DONE. The controller therefore sees `rqst = 0` when it returns to its idle state.
  - A transfer coinciding with `end_flag` is counted.
- **DONE** (one cycle)
  - `done = 1`, `done_count = xfer_cnt`.
  - `done_err = misaligned | (xfer_cnt != num_words)`.
  - Next state IDLE.
- **Read drain:** `rd_valid = !fifo_empty` in every state; FIFO contents drain after DONE. Because `cmd_ready` requires an empty FIFO, data never mixes across commands.
- **Write leftovers:** words still in the FIFO at DONE are flushed.
- **Zero words:** `rqst` is raised; the controller ends without transfers; DONE reports `done_count = 0` and `done_err = 0`.
- **Simultaneous push and pop** on the FIFO: both occur and occupancy is unchanged; allowed when full or empty only if the pop side is valid.
- **Reset mid-operation:** returns immediately to IDLE. The FIFO and all counters are cleared and `rqst` drops.

## Timing
- Reset values: `rqst`, `rd_wr`, `dev_ack`, `done`, `done_err`, `rd_valid`, `wr_ready` = 0. `num_words`, `start_addr`, `done_count`, `dev_in` = 0. `cmd_ready` = 1 after reset release.
- Command accept → `rqst` high: next edge (1 cycle).
- `end_flag` edge → `done` high: the following cycle.
- A word written from `dev_out` reaches `rd_valid` one cycle later.
- A word accepted on `wr_data` is presented on `dev_in` (with `dev_ack`) one cycle later.
- Full throughput: one word per cycle in each direction.

## Configuration
- DMA_DEV_TIMEOUT_EN defined:
  - A counter runs in XFER and is cleared on every transfer.
  - On reaching TIMEOUT_CYCLES: drop `rqst`, go to DONE with `done_err = 1`, flush the FIFO.
- Undefined: no counter; XFER waits indefinitely for `end_flag`.

## Structure
- Shared package `dma_pkg`: state encoding, default ADD_LEN/DATA_LEN, and direction constants (DIR_READ = 1, DIR_WRITE = 0).
- One sub-module, `dma_dev_fifo`: synchronous FIFO with parameter `BUF_DEPTH` and ports push, pop, flush, full, empty, din, dout.

## Test plan
- **Read, 4 words @ 0x0100:** controller returns 0xA1..0xA4 with `rd_ready = 1` → `rqst` deasserts after `end_flag`; `rd_data` sequence A1..A4; `done_count = 4`, `done_err = 0`.
- **Write, 3 words @ 0x0200:** words 0x11, 0x22, 0x33 given on `wr_data` → `dev_in` order 11, 22, 33 on the three handshakes; `done_count = 3`.
- **Read with `rd_ready = 0`, 12 words, BUF_DEPTH = 3:** `dev_ack` drops after 8 words; after `rd_ready` is raised, all 12 words are delivered in order.
- **`cmd_addr = 0x0101`:** `rqst` stays 0; `done = 1` and `done_err = 1` one cycle after accept.
- **`cmd_words = 0`:** `rqst` pulses; `end_flag` returned; `done_count = 0`, `done_err = 0`. A controller ending after 2 of 5 words → `done_err = 1`, `done_count = 2`.
- **Reset asserted mid-XFER, then timeout (macro on, TIMEOUT_CYCLES = 16):**
  - Reset: `rqst` returns to 0 immediately and the FIFO is empty.
  - Timeout: with no controller activity, `done_err = 1` at cycle 17 of XFER.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA device-side port: FSM encoding, default widths
// and transfer direction constants.
package dma_pkg;

  localparam int ADD_LEN_DEF  = 16;
  localparam int DATA_LEN_DEF = 16;

  localparam logic DIR_READ  = 1'b1;
  localparam logic DIR_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } dma_state_e;

endpackage

// File: rtl/dma_device_port_if.sv
// Local command/stream signals plus the DMA controller handshake of one device port.
// master = the device port itself, slave = peripheral core and controller side.
interface dma_device_port_if
  import dma_pkg::*;
#(
  parameter int ADD_LEN  = ADD_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF
) ();

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_rd_wr;
  logic [ADD_LEN-1:0]  cmd_words;
  logic [ADD_LEN:0]    cmd_addr;
  logic [DATA_LEN-1:0] wr_data;
  logic                wr_valid;
  logic                wr_ready;
  logic [DATA_LEN-1:0] rd_data;
  logic                rd_valid;
  logic                rd_ready;
  logic                done;
  logic                done_err;
  logic [ADD_LEN-1:0]  done_count;
  logic                rqst;
  logic                rd_wr;
  logic [ADD_LEN-1:0]  num_words;
  logic [ADD_LEN:0]    start_addr;
  logic                dev_ack;
  logic [DATA_LEN-1:0] dev_in;
  logic                dma_ack;
  logic [DATA_LEN-1:0] dev_out;
  logic                end_flag;

  modport master (
    input  cmd_valid, cmd_rd_wr, cmd_words, cmd_addr, wr_data, wr_valid, rd_ready,
           dma_ack, dev_out, end_flag,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, done_err, done_count,
           rqst, rd_wr, num_words, start_addr, dev_ack, dev_in
  );

  modport slave (
    output cmd_valid, cmd_rd_wr, cmd_words, cmd_addr, wr_data, wr_valid, rd_ready,
           dma_ack, dev_out, end_flag,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, done_err, done_count,
           rqst, rd_wr, num_words, start_addr, dev_ack, dev_in
  );

endinterface

// File: rtl/dma_dev_fifo.sv
// Synchronous FIFO of 2^BUF_DEPTH words; flush wins over push/pop, and a push
// into a full FIFO is taken only when a pop happens on the same edge.
module dma_dev_fifo #(
  parameter int DATA_LEN  = 16,
  parameter int BUF_DEPTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [DATA_LEN-1:0] din,
  output logic [DATA_LEN-1:0] dout,
  output logic                full,
  output logic                empty
);

  logic [DATA_LEN-1:0]  mem_q [2**BUF_DEPTH];
  logic [BUF_DEPTH-1:0] wr_ptr_q;
  logic [BUF_DEPTH-1:0] rd_ptr_q;
  logic [BUF_DEPTH:0]   cnt_q;
  logic                 do_push_s;
  logic                 do_pop_s;

  // Occupancy never exceeds 2^BUF_DEPTH, so the top count bit alone means full.
  assign full      = cnt_q[BUF_DEPTH];
  assign empty     = (cnt_q == '0);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < 2**BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dma_device_port.sv
// Device-side DMA request/handshake endpoint with a bidirectional word FIFO.
// Optional transfer watchdog is compiled in with DMA_DEV_TIMEOUT_EN.
module dma_device_port
  import dma_pkg::*;
#(
  parameter int ADD_LEN        = ADD_LEN_DEF,
  parameter int DATA_LEN       = DATA_LEN_DEF,
  parameter int BUF_DEPTH      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              reset,
  dma_device_port_if.master bus
);

  dma_state_e          state_q, state_d;
  logic                rqst_q, rqst_d;
  logic                rd_wr_q, rd_wr_d;
  logic [ADD_LEN-1:0]  num_words_q, num_words_d;
  logic [ADD_LEN:0]    start_addr_q, start_addr_d;
  logic [ADD_LEN-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic                done_q, done_d;
  logic                done_err_q, done_err_d;
  logic [ADD_LEN-1:0]  done_count_q, done_count_d;
  logic                tmo_q, tmo_d;

  logic                in_xfer_s, dev_ack_s, xfer_s, cmd_ready_s;
  logic                wr_ready_s, rd_valid_s, tmo_fire_s;
  logic                fifo_push_s, fifo_pop_s, fifo_flush_s, fifo_full_s, fifo_empty_s;
  logic [DATA_LEN-1:0] fifo_din_s, fifo_dout_s;

  assign in_xfer_s   = (state_q == ST_XFER);
  assign dev_ack_s   = in_xfer_s && ((rd_wr_q == DIR_READ) ? !fifo_full_s : !fifo_empty_s);
  assign xfer_s      = bus.dma_ack && dev_ack_s;
  assign cmd_ready_s = (state_q == ST_IDLE) && fifo_empty_s;
  assign wr_ready_s  = in_xfer_s && (rd_wr_q == DIR_WRITE) && !fifo_full_s;
  // Read words stay visible after DONE until drained; write words never leak out here.
  assign rd_valid_s  = (rd_wr_q == DIR_READ) && !fifo_empty_s;

  assign fifo_push_s  = (rd_wr_q == DIR_READ) ? xfer_s : (bus.wr_valid && wr_ready_s);
  assign fifo_pop_s   = (rd_wr_q == DIR_READ) ? (rd_valid_s && bus.rd_ready) : xfer_s;
  assign fifo_din_s   = (rd_wr_q == DIR_READ) ? bus.dev_out : bus.wr_data;
  assign fifo_flush_s = (state_q == ST_DONE) && ((rd_wr_q == DIR_WRITE) || tmo_q);

`ifdef DMA_DEV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] to_cnt_q;

  assign tmo_fire_s = in_xfer_s && !xfer_s && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle-cycle watchdog, restarted by every word transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (!in_xfer_s || xfer_s) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_fire_s = 1'b0;
`endif

  dma_dev_fifo #(
    .DATA_LEN  (DATA_LEN),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .flush (fifo_flush_s),
    .din   (fifo_din_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state and next-output logic for the command FSM
  always_comb begin
    state_d      = state_q;
    rqst_d       = rqst_q;
    rd_wr_d      = rd_wr_q;
    num_words_d  = num_words_q;
    start_addr_d = start_addr_q;
    xfer_cnt_d   = xfer_cnt_q;
    done_d       = 1'b0;
    done_err_d   = 1'b0;
    done_count_d = done_count_q;
    tmo_d        = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_s) begin
          rd_wr_d      = bus.cmd_rd_wr;
          num_words_d  = bus.cmd_words;
          start_addr_d = bus.cmd_addr;
          xfer_cnt_d   = '0;
          tmo_d        = 1'b0;
          if (bus.cmd_addr[0]) begin
            state_d      = ST_DONE;
            done_d       = 1'b1;
            done_err_d   = 1'b1;
            done_count_d = '0;
          end else begin
            rqst_d  = 1'b1;
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (xfer_s) begin
          xfer_cnt_d = xfer_cnt_q + 1'b1;
        end else begin
          xfer_cnt_d = xfer_cnt_q;
        end
        // A word moving on the end_flag edge is already included in xfer_cnt_d.
        if (bus.end_flag) begin
          rqst_d       = 1'b0;
          state_d      = ST_DONE;
          done_d       = 1'b1;
          done_count_d = xfer_cnt_d;
          done_err_d   = (xfer_cnt_d != num_words_q);
        end else if (tmo_fire_s) begin
          rqst_d       = 1'b0;
          state_d      = ST_DONE;
          done_d       = 1'b1;
          done_count_d = xfer_cnt_q;
          done_err_d   = 1'b1;
          tmo_d        = 1'b1;
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        rqst_d  = 1'b0;
      end
    endcase
  end

  // FSM and request/status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rqst_q       <= 1'b0;
      rd_wr_q      <= 1'b0;
      num_words_q  <= '0;
      start_addr_q <= '0;
      xfer_cnt_q   <= '0;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
      done_count_q <= '0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rqst_q       <= rqst_d;
      rd_wr_q      <= rd_wr_d;
      num_words_q  <= num_words_d;
      start_addr_q <= start_addr_d;
      xfer_cnt_q   <= xfer_cnt_d;
      done_q       <= done_d;
      done_err_q   <= done_err_d;
      done_count_q <= done_count_d;
      tmo_q        <= tmo_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_s;
  assign bus.wr_ready   = wr_ready_s;
  assign bus.rd_valid   = rd_valid_s;
  assign bus.rd_data    = fifo_dout_s;
  assign bus.dev_ack    = dev_ack_s;
  assign bus.dev_in     = fifo_dout_s;
  assign bus.rqst       = rqst_q;
  assign bus.rd_wr      = rd_wr_q;
  assign bus.num_words  = num_words_q;
  assign bus.start_addr = start_addr_q;
  assign bus.done       = done_q;
  assign bus.done_err   = done_err_q;
  assign bus.done_count = done_count_q;

endmodule

// File: tb/tb_dma_device_port.sv
// Directed bench for dma_device_port: emulates the DMA controller and peripheral,
// scoreboarding read words, write words and completion status.
module tb_dma_device_port;
  import dma_pkg::*;

  typedef struct packed {
    logic        err;
    logic [15:0] cnt;
  } done_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] rd_exp_q[$];
  logic [15:0] wr_exp_q[$];
  done_t       done_exp_q[$];

  always #5 clk = ~clk;

  dma_device_port_if #(.ADD_LEN(16), .DATA_LEN(16)) bus ();

  dma_device_port #(
    .ADD_LEN        (16),
    .DATA_LEN       (16),
    .BUF_DEPTH      (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every handshake and completion the DUT produces.
  always @(negedge clk) begin
    logic [15:0] e;
    done_t       d;
    if (reset === 1'b0) begin
      if (bus.rd_valid && bus.rd_ready) begin
        e = (rd_exp_q.size() > 0) ? rd_exp_q.pop_front() : 16'hdead;
        checks++;
        assert (bus.rd_data === e) else begin
          errors++;
          $error("FAIL rd_data observed %h expected %h", bus.rd_data, e);
        end
      end
      if (bus.dev_ack && bus.dma_ack && (bus.rd_wr == DIR_WRITE)) begin
        e = (wr_exp_q.size() > 0) ? wr_exp_q.pop_front() : 16'hdead;
        checks++;
        assert (bus.dev_in === e) else begin
          errors++;
          $error("FAIL dev_in observed %h expected %h", bus.dev_in, e);
        end
      end
      if (bus.done) begin
        d = (done_exp_q.size() > 0) ? done_exp_q.pop_front() : done_t'({1'b1, 16'hdead});
        checks++;
        assert ({bus.done_err, bus.done_count} === d) else begin
          errors++;
          $error("FAIL done_status observed err=%b cnt=%0d expected err=%b cnt=%0d",
                 bus.done_err, bus.done_count, d.err, d.cnt);
        end
      end
    end
  end

  task automatic issue_cmd(input logic dir, input logic [15:0] words, input logic [16:0] addr);
    int b = 0;
    while (bus.cmd_ready !== 1'b1 && b < 100) begin
      tick();
      b++;
    end
    chk("cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rd_wr = dir;
    bus.cmd_words = words;
    bus.cmd_addr  = addr;
    tick();
    bus.cmd_valid = 1'b0;
    chk("rqst_after_accept", {31'd0, bus.rqst}, {31'd0, !addr[0]});
    chk("start_addr", {15'd0, bus.start_addr}, {15'd0, addr});
    chk("num_words", {16'd0, bus.num_words}, {16'd0, words});
    chk("rd_wr", {31'd0, bus.rd_wr}, {31'd0, dir});
  endtask

  // Controller side of a read: offers base+i, optionally ends with the last word.
  task automatic ctrl_read(input logic [15:0] base, input int n, input logic last);
    int i = 0;
    int b = 0;
    while (i < n && b < 200) begin
      bus.dma_ack  = 1'b1;
      bus.dev_out  = 16'(base + i);
      bus.end_flag = last && (i == n - 1) && bus.dev_ack;
      if (bus.dev_ack) begin
        rd_exp_q.push_back(16'(base + i));
        i++;
      end
      tick();
      b++;
    end
    bus.dma_ack  = 1'b0;
    bus.end_flag = 1'b0;
    chk("read_words_moved", i, n);
    if (last && n == 0) begin
      bus.end_flag = 1'b1;
      tick();
      bus.end_flag = 1'b0;
    end
    if (last) chk("rqst_dropped", {31'd0, bus.rqst}, 32'd0);
  endtask

  // Peripheral feeds nfeed words base*(k+1), then the controller takes nack of them.
  task automatic ctrl_write(input logic [15:0] base, input int nfeed, input int nack);
    int k = 0;
    int i = 0;
    int b = 0;
    while (k < nfeed && b < 100) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'(base * (k + 1));
      if (bus.wr_ready) k++;
      tick();
      b++;
    end
    bus.wr_valid = 1'b0;
    chk("words_fed", k, nfeed);
    chk("dev_ack_write", {31'd0, bus.dev_ack}, {31'd0, nfeed > 0});
    while (i < nack && b < 200) begin
      bus.dma_ack  = 1'b1;
      bus.end_flag = (i == nack - 1) && bus.dev_ack;
      if (bus.dev_ack) begin
        wr_exp_q.push_back(16'(base * (i + 1)));
        i++;
      end
      tick();
      b++;
    end
    bus.dma_ack  = 1'b0;
    bus.end_flag = 1'b0;
    chk("write_acks", i, nack);
    chk("rqst_dropped_wr", {31'd0, bus.rqst}, 32'd0);
  endtask

  task automatic wait_drain();
    int b = 0;
    while (rd_exp_q.size() > 0 && b < 100) begin
      tick();
      b++;
    end
    chk("rd_drained", rd_exp_q.size(), 0);
    chk("rd_valid_empty", {31'd0, bus.rd_valid}, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_rd_wr = 1'b0;
    bus.cmd_words = 16'd0;
    bus.cmd_addr  = 17'd0;
    bus.wr_data   = 16'd0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b1;
    bus.dma_ack   = 1'b0;
    bus.dev_out   = 16'd0;
    bus.end_flag  = 1'b0;
    tick();
    tick();
    chk("rst_rqst", {31'd0, bus.rqst}, 32'd0);
    chk("rst_rd_wr", {31'd0, bus.rd_wr}, 32'd0);
    chk("rst_dev_ack", {31'd0, bus.dev_ack}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_done_err", {31'd0, bus.done_err}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
    chk("rst_num_words", {16'd0, bus.num_words}, 32'd0);
    chk("rst_start_addr", {15'd0, bus.start_addr}, 32'd0);
    chk("rst_done_count", {16'd0, bus.done_count}, 32'd0);
    chk("rst_dev_in", {16'd0, bus.dev_in}, 32'd0);
    reset = 1'b0;
    tick();
    chk("cmd_ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);

    // Read 4 words at 0x0100
    done_exp_q.push_back('{1'b0, 16'd4});
    issue_cmd(DIR_READ, 16'd4, 17'h0100);
    ctrl_read(16'h00A1, 4, 1'b1);
    wait_drain();

    // Write 3 words at 0x0200
    done_exp_q.push_back('{1'b0, 16'd3});
    issue_cmd(DIR_WRITE, 16'd3, 17'h0200);
    ctrl_write(16'h0011, 3, 3);
    tick();
    chk("wr_sb_empty", wr_exp_q.size(), 0);

    // Read 12 words with the consumer stalled: FIFO fills at 8
    bus.rd_ready = 1'b0;
    done_exp_q.push_back('{1'b0, 16'd12});
    issue_cmd(DIR_READ, 16'd12, 17'h0400);
    ctrl_read(16'h00B0, 8, 1'b0);
    tick();
    chk("dev_ack_full", {31'd0, bus.dev_ack}, 32'd0);
    chk("rd_valid_full", {31'd0, bus.rd_valid}, 32'd1);
    bus.rd_ready = 1'b1;
    ctrl_read(16'h00B8, 4, 1'b1);
    wait_drain();

    // Misaligned address: no request, immediate error completion
    done_exp_q.push_back('{1'b1, 16'd0});
    issue_cmd(DIR_READ, 16'd4, 17'h0101);
    chk("mis_done", {31'd0, bus.done}, 32'd1);
    chk("mis_done_err", {31'd0, bus.done_err}, 32'd1);
    tick();

    // Zero-word command
    done_exp_q.push_back('{1'b0, 16'd0});
    issue_cmd(DIR_READ, 16'd0, 17'h0300);
    ctrl_read(16'h0000, 0, 1'b1);
    tick();

    // Short transfers: controller ends after 2 of 5 words
    done_exp_q.push_back('{1'b1, 16'd2});
    issue_cmd(DIR_READ, 16'd5, 17'h0500);
    ctrl_read(16'h00C0, 2, 1'b1);
    wait_drain();
    done_exp_q.push_back('{1'b1, 16'd2});
    issue_cmd(DIR_WRITE, 16'd5, 17'h0600);
    ctrl_write(16'h0005, 5, 2);
    tick();
    chk("flush_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("flush_rd_valid", {31'd0, bus.rd_valid}, 32'd0);

    // Reset in the middle of a read with words buffered
    bus.rd_ready = 1'b0;
    issue_cmd(DIR_READ, 16'd4, 17'h0700);
    ctrl_read(16'h00D0, 2, 1'b0);
    chk("pre_reset_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_rqst", {31'd0, bus.rqst}, 32'd0);
    chk("reset_fifo_empty", {31'd0, bus.rd_valid}, 32'd0);
    chk("reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    rd_exp_q.delete();
    tick();
    reset = 1'b0;
    bus.rd_ready = 1'b1;
    tick();

`ifdef DMA_DEV_TIMEOUT_EN
    // Watchdog: no controller activity, error completion on XFER cycle 17
    done_exp_q.push_back('{1'b1, 16'd0});
    issue_cmd(DIR_READ, 16'd2, 17'h0800);
    repeat (15) tick();
    chk("tmo_not_yet", {31'd0, bus.done}, 32'd0);
    tick();
    chk("tmo_done", {31'd0, bus.done}, 32'd1);
    chk("tmo_done_err", {31'd0, bus.done_err}, 32'd1);
    chk("tmo_rqst", {31'd0, bus.rqst}, 32'd0);
    tick();
`endif

    tick();
    chk("done_sb_empty", done_exp_q.size(), 0);
    chk("rd_sb_empty", rd_exp_q.size(), 0);
    chk("wr_sb_final", wr_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
